// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between an initiator and dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with byte strobes and programmable wait states
module dmem_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      wait_cnt;

  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_wstrb;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata_q;
  logic            err_q;

  logic            accept;
  logic            enter_resp;
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_wstrb;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt <= 4'd1) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
    bus.rsp_err   = (state == RESP) ? err_q : 1'b0;
  end

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // With no wait states the access happens on the accept edge itself,
  // before the latches hold the request, so take it straight off the bus.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wstrb = bus.req_wstrb;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
  assign acc_idx = acc_addr[AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (accept) begin
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_wstrb <= bus.req_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= WAIT_LD;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
      err_q   <= acc_err;
    end
  end

endmodule
